// File: rtl/mac_reg_pkg.sv
// Shared definitions for the MAC/PHY register bank: register-type encoding
// and the standard MII register word indices.
package mac_reg_pkg;

   typedef enum logic [1:0] {
      REG_RW   = 2'd0,
      REG_RO   = 2'd1,
      REG_W1C  = 2'd2,
      REG_NONE = 2'd3
   } reg_type_e;

   localparam int MII_BMCR   = 0;
   localparam int MII_BMSR   = 1;
   localparam int MII_PHYID1 = 2;
   localparam int MII_PHYID2 = 3;
   localparam int MII_ANAR   = 4;
   localparam int MII_ANLPAR = 5;
   localparam int MII_ANER   = 6;
   localparam int MII_ANNPTR = 7;
   localparam int MII_ANLPNP = 8;
   localparam int MII_GBCR   = 9;
   localparam int MII_GBSR   = 10;
   localparam int MII_GBESR  = 15;

endpackage

// File: rtl/mac_reg_cell.sv
// One register of the bank: type-dependent CPU write / hardware set-clear
// priority, loaded with INIT on synchronous reset.
module mac_reg_cell
   import mac_reg_pkg::*;
#(
   parameter int                DATA_W = 16,
   parameter reg_type_e         TYPE   = REG_RW,
   parameter logic [DATA_W-1:0] INIT   = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_en_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [DATA_W-1:0] hw_set_i,
   input  logic [DATA_W-1:0] hw_clr_i,
   output logic [DATA_W-1:0] q_o
);

   logic [DATA_W-1:0] val_q, val_d;

   // RW: a CPU write overrides hardware strobes so re-armed command bits stick.
   // W1C: hardware set beats a same-cycle software clear so no event is lost.
   always_comb begin
      val_d = val_q;
      case (TYPE)
         REG_RW:  val_d = wr_en_i ? wr_data_i : ((val_q & ~hw_clr_i) | hw_set_i);
         REG_W1C: val_d = (val_q & ~(wr_en_i ? wr_data_i : '0)) | hw_set_i;
         default: val_d = val_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) val_q <= INIT;
      else       val_q <= val_d;
   end

   assign q_o = val_q;

endmodule

// File: rtl/mac_reg_bank.sv
// CPU-accessible MAC register bank with a 2*DATA_W wide counter window.
// Define MAC_REG_BANK_SNAPSHOT_EN to make the wide counter read atomic via a shadow.
module mac_reg_bank
   import mac_reg_pkg::*;
#(
   parameter int                         NUM_REGS = 48,
   parameter int                         DATA_W   = 16,
   parameter int                         ADDR_W   = 8,
   parameter logic [2*NUM_REGS-1:0]      REG_TYPE = '0,
   parameter logic [NUM_REGS*DATA_W-1:0] REG_INIT = '0,
   parameter int                         WIDE_IDX = 31
) (
   input  logic                         Clk_reg,
   input  logic                         Reset,
   input  logic                         CSB,
   input  logic                         WRB,
   input  logic [ADDR_W-1:0]            CA,
   input  logic [DATA_W-1:0]            CD_in,
   output logic [DATA_W-1:0]            CD_out,
   output logic                         ACK,
   output logic [NUM_REGS*DATA_W-1:0]   reg_q,
   input  logic [NUM_REGS*DATA_W-1:0]   ro_din,
   input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
   input  logic [NUM_REGS*DATA_W-1:0]   hw_clr,
   input  logic [2*DATA_W-1:0]          wide_din
);

   logic [ADDR_W-2:0]   idx;
   logic                unused_ca0;
   logic                rd_cmd, wr_cmd;
   logic [NUM_REGS-1:0] wr_en;
   logic [DATA_W-1:0]   rd_word;
   logic [DATA_W-1:0]   cd_out_q, cd_out_d;
   logic                ack_q, ack_d;

   assign idx        = CA[ADDR_W-1:1];
   assign unused_ca0 = CA[0];
   assign rd_cmd     = !CSB && WRB;
   assign wr_cmd     = !CSB && !WRB;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      assign wr_en[g] = wr_cmd && (int'(idx) == g);

      mac_reg_cell #(
         .DATA_W (DATA_W),
         .TYPE   (reg_type_e'(REG_TYPE[2*g +: 2])),
         .INIT   (REG_INIT[g*DATA_W +: DATA_W])
      ) u_cell (
         .clk_i     (Clk_reg),
         .rst_i     (Reset),
         .wr_en_i   (wr_en[g]),
         .wr_data_i (CD_in),
         .hw_set_i  (hw_set[g*DATA_W +: DATA_W]),
         .hw_clr_i  (hw_clr[g*DATA_W +: DATA_W]),
         .q_o       (reg_q[g*DATA_W +: DATA_W])
      );
   end

`ifdef MAC_REG_BANK_SNAPSHOT_EN
   logic [DATA_W-1:0] shadow_q, shadow_d;

   // Reading the low word freezes the high word so both halves match.
   always_comb begin
      shadow_d = shadow_q;
      if (rd_cmd && int'(idx) == WIDE_IDX) shadow_d = wide_din[2*DATA_W-1:DATA_W];
   end

   always_ff @(posedge Clk_reg) begin
      if (Reset) shadow_q <= '0;
      else       shadow_q <= shadow_d;
   end
`endif

   // Read data is taken from pre-edge register state; out-of-range yields 0.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (int'(idx) == i) begin
            case (reg_type_e'(REG_TYPE[2*i +: 2]))
               REG_RO:   rd_word = ro_din[i*DATA_W +: DATA_W];
               REG_NONE: rd_word = '0;
               default:  rd_word = reg_q[i*DATA_W +: DATA_W];
            endcase
         end
      end
      if (int'(idx) == WIDE_IDX) begin
         rd_word = wide_din[DATA_W-1:0];
      end else if (int'(idx) == WIDE_IDX + 1) begin
`ifdef MAC_REG_BANK_SNAPSHOT_EN
         rd_word = shadow_q;
`else
         rd_word = wide_din[2*DATA_W-1:DATA_W];
`endif
      end
   end

   assign cd_out_d = rd_cmd ? rd_word : '0;
   assign ack_d    = !CSB && !ack_q;

   always_ff @(posedge Clk_reg) begin
      if (Reset) begin
         cd_out_q <= '0;
         ack_q    <= 1'b0;
      end else begin
         cd_out_q <= cd_out_d;
         ack_q    <= ack_d;
      end
   end

   assign CD_out = cd_out_q;
   assign ACK    = ack_q;

endmodule

// File: tb/tb_mac_reg_bank.sv
// Self-checking bench for mac_reg_bank: directed literal checks plus a
// randomized run against a cycle-level behavioural model.
module tb_mac_reg_bank;

   localparam int NR = 48;
   localparam int DW = 16;
   localparam int AW = 8;
   localparam int WI = 31;

   function automatic logic [2*NR-1:0] mk_types();
      logic [2*NR-1:0] t;
      t = '0;
      t[2*1  +: 2] = 2'd1;
      t[2*2  +: 2] = 2'd1;
      t[2*3  +: 2] = 2'd1;
      t[2*40 +: 2] = 2'd2;
      t[2*41 +: 2] = 2'd2;
      t[2*44 +: 2] = 2'd3;
      t[2*45 +: 2] = 2'd3;
      return t;
   endfunction

   function automatic logic [NR*DW-1:0] mk_init();
      logic [NR*DW-1:0] t;
      t = '0;
      t[DW*0  +: DW] = 16'h001E;
      t[DW*1  +: DW] = 16'h7849;
      t[DW*5  +: DW] = 16'h1140;
      t[DW*41 +: DW] = 16'h0F0F;
      t[DW*44 +: DW] = 16'h5555;
      return t;
   endfunction

   localparam logic [2*NR-1:0]  TYPES = mk_types();
   localparam logic [NR*DW-1:0] INIT  = mk_init();

   logic              clk = 1'b0;
   logic              rst, csb, wrb;
   logic [AW-1:0]     ca;
   logic [DW-1:0]     cd_in;
   logic [DW-1:0]     cd_out;
   logic              ack;
   logic [NR*DW-1:0]  reg_q, ro_din, hw_set, hw_clr;
   logic [2*DW-1:0]   wide_din;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   logic [DW-1:0] m_reg [NR];
   logic [DW-1:0] m_cd;
   logic          m_ack;
`ifdef MAC_REG_BANK_SNAPSHOT_EN
   logic [DW-1:0] m_sh;
`endif

   mac_reg_bank #(
      .NUM_REGS (NR), .DATA_W (DW), .ADDR_W (AW),
      .REG_TYPE (TYPES), .REG_INIT (INIT), .WIDE_IDX (WI)
   ) dut (
      .Clk_reg (clk), .Reset (rst), .CSB (csb), .WRB (wrb), .CA (ca),
      .CD_in (cd_in), .CD_out (cd_out), .ACK (ack), .reg_q (reg_q),
      .ro_din (ro_din), .hw_set (hw_set), .hw_clr (hw_clr), .wide_din (wide_din)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] type_of(input int i);
      return TYPES[2*i +: 2];
   endfunction

   // Model of one clock edge, evaluated from the inputs present at that edge.
   task automatic model_update();
      int            idx;
      logic [DW-1:0] rd, s, c;
      if (rst) begin
         for (int i = 0; i < NR; i++) m_reg[i] = INIT[i*DW +: DW];
         m_cd  = '0;
         m_ack = 1'b0;
`ifdef MAC_REG_BANK_SNAPSHOT_EN
         m_sh  = '0;
`endif
         return;
      end
      idx = int'(ca[AW-1:1]);
      rd  = '0;
      if (!csb && wrb) begin
         if (idx == WI)          rd = wide_din[DW-1:0];
`ifdef MAC_REG_BANK_SNAPSHOT_EN
         else if (idx == WI + 1) rd = m_sh;
`else
         else if (idx == WI + 1) rd = wide_din[2*DW-1:DW];
`endif
         else if (idx < NR) begin
            if (type_of(idx) == 2'd1)      rd = ro_din[idx*DW +: DW];
            else if (type_of(idx) == 2'd3) rd = '0;
            else                           rd = m_reg[idx];
         end
`ifdef MAC_REG_BANK_SNAPSHOT_EN
         if (idx == WI) m_sh = wide_din[2*DW-1:DW];
`endif
      end
      m_cd  = rd;
      m_ack = !csb && !m_ack;
      for (int i = 0; i < NR; i++) begin
         s = hw_set[i*DW +: DW];
         c = hw_clr[i*DW +: DW];
         if (type_of(i) == 2'd0) begin
            if (!csb && !wrb && idx == i) m_reg[i] = cd_in;
            else                          m_reg[i] = (m_reg[i] & ~c) | s;
         end else if (type_of(i) == 2'd2) begin
            if (!csb && !wrb && idx == i) m_reg[i] = m_reg[i] & ~cd_in;
            m_reg[i] = m_reg[i] | s;
         end
      end
   endtask

   // Single compare process: every enabled cycle, all outputs vs. the model.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [NR*DW-1:0] flat;
         for (int i = 0; i < NR; i++) flat[i*DW +: DW] = m_reg[i];
         chk("cd_out", cd_out, m_cd);
         chk("ack", {15'b0, ack}, {15'b0, m_ack});
         n_chk++;
         if (reg_q !== flat) begin
            n_fail++;
            $display("FAIL reg_q: got %h expected %h", reg_q, flat);
         end
      end
   end

   task automatic cyc(input logic c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      csb = c; wrb = w; ca = a; cd_in = d;
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; csb = 1'b1; wrb = 1'b1; ca = '0; cd_in = '0;
      ro_din = '0; hw_set = '0; hw_clr = '0; wide_din = '0;
      @(negedge clk);
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      chk_en = 1'b1;
      rst = 1'b0;
      chk("rst_cd", cd_out, 16'h0000);
      chk("rst_ack", {15'b0, ack}, 16'h0000);
      chk("rst_reg44", reg_q[44*DW +: DW], 16'h5555);

      // Read of index 0 and the two-cycle ACK handshake
      cyc(0, 1, 8'd0, 0);
      chk("r0_data", cd_out, 16'h001E);
      chk("r0_ack1", {15'b0, ack}, 16'h0001);
      cyc(0, 1, 8'd0, 0);
      chk("r0_ack2", {15'b0, ack}, 16'h0000);
      cyc(1, 1, 8'd0, 0);
      chk("idle_cd", cd_out, 16'h0000);

      // RW index 36: CPU write beats hw_clr
      cyc(0, 0, 8'd72, 16'h0004);
      chk("rw36_wr", reg_q[36*DW +: DW], 16'h0004);
      hw_clr[36*DW +: DW] = 16'h0004;
      cyc(0, 0, 8'd72, 16'h0006);
      chk("rw36_prio", reg_q[36*DW +: DW], 16'h0006);
      cyc(1, 1, 8'd0, 0);
      chk("rw36_clr", reg_q[36*DW +: DW], 16'h0002);
      hw_clr = '0;

      // W1C index 40: hw_set beats same-cycle clear
      hw_set[40*DW +: DW] = 16'h0003;
      cyc(1, 1, 8'd0, 0);
      chk("w1c_set", reg_q[40*DW +: DW], 16'h0003);
      hw_set[40*DW +: DW] = 16'h0001;
      cyc(0, 0, 8'd80, 16'h0001);
      chk("w1c_prio", reg_q[40*DW +: DW], 16'h0003);
      hw_set = '0;
      cyc(0, 0, 8'd80, 16'h0003);
      chk("w1c_clr", reg_q[40*DW +: DW], 16'h0000);

      // Wide counter halves
      wide_din = 32'h1234_5678;
      cyc(0, 1, 8'd62, 0);
      chk("wide_lo", cd_out, 16'h5678);
      wide_din = 32'hAAAA_0000;
      cyc(0, 1, 8'd64, 0);
`ifdef MAC_REG_BANK_SNAPSHOT_EN
      chk("wide_hi", cd_out, 16'h1234);
`else
      chk("wide_hi", cd_out, 16'hAAAA);
`endif

      // Ignored writes: RO, unimplemented, out of range
      cyc(0, 0, 8'd2, 16'hFFFF);
      cyc(0, 0, 8'd88, 16'hFFFF);
      cyc(0, 0, 8'd96, 16'hFFFF);
      chk("ro_keep", reg_q[1*DW +: DW], 16'h7849);
      chk("none_keep", reg_q[44*DW +: DW], 16'h5555);
      cyc(0, 1, 8'd88, 0);
      chk("none_rd", cd_out, 16'h0000);
      cyc(0, 1, 8'd96, 0);
      chk("oor_rd", cd_out, 16'h0000);

      // Reset wins over a concurrent write
      cyc(1, 1, 8'd0, 0);
      rst = 1'b1;
      cyc(0, 0, 8'd72, 16'hBEEF);
      rst = 1'b0;
      chk("rstwr_reg", reg_q[36*DW +: DW], 16'h0000);
      chk("rstwr_ack", {15'b0, ack}, 16'h0000);
      chk("rstwr_cd", cd_out, 16'h0000);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < NR; i++) begin
            hw_set[i*DW +: DW] = DW'($urandom & $urandom & $urandom);
            hw_clr[i*DW +: DW] = DW'($urandom & $urandom & $urandom);
            ro_din[i*DW +: DW] = DW'($urandom);
         end
         wide_din = $urandom;
         cyc(($urandom_range(0, 3) == 0), $urandom_range(0, 1),
             ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 99)),
             DW'($urandom));
      end
      rst = 1'b0;
      cyc(1, 1, 0, 0);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
